// File: rtl/analyzer_pkg.sv
// Shared types for the logic-analyzer capture path and its slave.
package analyzer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRETRIG   = 2'd1,
        WAIT_TRIG = 2'd2,
        POST      = 2'd3
    } cap_state_t;

    // Global trigger-combiner modes, decoded by the slave register block.
    localparam logic [1:0] GLOBAL_AND  = 2'd0;
    localparam logic [1:0] GLOBAL_OR   = 2'd1;
    localparam logic [1:0] GLOBAL_NAND = 2'd2;
    localparam logic [1:0] GLOBAL_NOR  = 2'd3;

endpackage

// File: rtl/analyzer_sdp_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module analyzer_sdp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Only the output register is reset; the array itself keeps its contents.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rdata_q <= '0;
        else       rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/analyzer_capture_buffer.sv
// Decimated circular capture with pre-trigger window; read port is
// linearised so address 0 is always the oldest stored sample.
module analyzer_capture_buffer
    import analyzer_pkg::*;
#(
    parameter int DIGITAL_IN_NUM  = 8,
    parameter int WAVE_ADDR_WIDTH = 12,
    parameter int DIV_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [DIGITAL_IN_NUM-1:0]  digital_in,
    input  logic                       arm,
    input  logic                       abort,
    input  logic                       trig,
    input  logic [WAVE_ADDR_WIDTH-1:0] pre_trig_len,
    input  logic [DIV_WIDTH-1:0]       sample_div,
    input  logic [WAVE_ADDR_WIDTH-1:0] wave_addr,
    output logic [DIGITAL_IN_NUM-1:0]  wave_out,
    output logic                       busy,
    output logic                       waiting,
    output logic                       done,
    output logic                       trig_seen
);

    localparam int AW = WAVE_ADDR_WIDTH;
    localparam int DW = DIV_WIDTH;
    localparam logic [AW-1:0] LAST = '1;

    cap_state_t state_q, state_d;
    logic [DIGITAL_IN_NUM-1:0] din_s1_q, din_s2_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d, div_l_q, div_l_d;
    logic [AW-1:0] pre_l_q, pre_l_d, pre_cnt_q, pre_cnt_d, pre_cnt_inc;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d;
    logic [AW-1:0] post_left_q, post_left_d;
    logic trig_pend_q, trig_pend_d, done_q, done_d, trig_seen_q, trig_seen_d;
    logic tick, trig_hit, we;

    assign busy        = (state_q != IDLE);
    assign waiting     = (state_q == PRETRIG) || (state_q == WAIT_TRIG);
    assign done        = done_q;
    assign trig_seen   = trig_seen_q;
    assign tick        = busy && (div_cnt_q == div_l_q);
    assign trig_hit    = trig | trig_pend_q;
    assign pre_cnt_inc = pre_cnt_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        div_l_d     = div_l_q;
        pre_l_d     = pre_l_q;
        pre_cnt_d   = pre_cnt_q;
        start_ptr_d = start_ptr_q;
        post_left_d = post_left_q;
        trig_pend_d = trig_pend_q;
        done_d      = done_q;
        trig_seen_d = 1'b0;
        we          = 1'b0;
        div_cnt_d   = busy ? (tick ? '0 : div_cnt_q + DW'(1)) : div_cnt_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d     = PRETRIG;
                    pre_l_d     = pre_trig_len;
                    div_l_d     = sample_div;
                    done_d      = 1'b0;
                    pre_cnt_d   = '0;
                    div_cnt_d   = '0;
                    trig_pend_d = 1'b0;
                end
            end
            PRETRIG: begin
                // An empty pre-trigger window skips straight on without writing.
                if (pre_l_q == '0) begin
                    state_d = WAIT_TRIG;
                end else if (tick) begin
                    we        = 1'b1;
                    pre_cnt_d = pre_cnt_inc;
                    if (pre_cnt_inc == pre_l_q) state_d = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (tick) begin
                    we = 1'b1;
                    if (trig_hit) begin
                        start_ptr_d = wr_ptr_q - pre_l_q;
                        post_left_d = LAST - pre_l_q;
                        trig_seen_d = 1'b1;
                        trig_pend_d = 1'b0;
                        if (pre_l_q == LAST) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = POST;
                        end
                    end
                end else if (trig) begin
                    trig_pend_d = 1'b1;
                end
            end
            POST: begin
                if (tick) begin
                    we          = 1'b1;
                    post_left_d = post_left_q - AW'(1);
                    if (post_left_q == AW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            done_d      = 1'b0;
            trig_pend_d = 1'b0;
            trig_seen_d = 1'b0;
            we          = 1'b0;
        end

        wr_ptr_d = we ? wr_ptr_q + AW'(1) : wr_ptr_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            din_s1_q    <= '0;
            din_s2_q    <= '0;
            div_cnt_q   <= '0;
            div_l_q     <= '0;
            pre_l_q     <= '0;
            pre_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            post_left_q <= '0;
            trig_pend_q <= 1'b0;
            done_q      <= 1'b0;
            trig_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            din_s1_q    <= digital_in;
            din_s2_q    <= din_s1_q;
            div_cnt_q   <= div_cnt_d;
            div_l_q     <= div_l_d;
            pre_l_q     <= pre_l_d;
            pre_cnt_q   <= pre_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            post_left_q <= post_left_d;
            trig_pend_q <= trig_pend_d;
            done_q      <= done_d;
            trig_seen_q <= trig_seen_d;
        end
    end

    analyzer_sdp_ram #(
        .DATA_W (DIGITAL_IN_NUM),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (din_s2_q),
        .raddr_i (start_ptr_q + wave_addr),
        .rdata_o (wave_out)
    );

endmodule

// File: tb/tb_analyzer_capture_buffer.sv
// Directed bench with a read-data scoreboard for analyzer_capture_buffer (DEPTH=16).
module tb_analyzer_capture_buffer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  digital_in = 8'h00;
    logic        arm = 1'b0, abort = 1'b0, trig = 1'b0;
    logic [3:0]  pre_trig_len = 4'd0;
    logic [15:0] sample_div = 16'd0;
    logic [3:0]  wave_addr = 4'd0;
    logic [7:0]  wave_out;
    logic        busy, waiting, done, trig_seen;

    int checks = 0, errors = 0, ts_cnt = 0;
    logic rd_en = 1'b0;
    logic [7:0] exp_q [$];

    analyzer_capture_buffer #(
        .DIGITAL_IN_NUM (8),
        .WAVE_ADDR_WIDTH(4),
        .DIV_WIDTH      (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .digital_in  (digital_in),
        .arm         (arm),
        .abort       (abort),
        .trig        (trig),
        .pre_trig_len(pre_trig_len),
        .sample_div  (sample_div),
        .wave_addr   (wave_addr),
        .wave_out    (wave_out),
        .busy        (busy),
        .waiting     (waiting),
        .done        (done),
        .trig_seen   (trig_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts trig_seen pulses and scores read data one clock after each request.
    initial begin : mon
        logic fire;
        forever begin
            @(posedge clk);
            fire = rd_en;
            #1;
            if (trig_seen) ts_cnt++;
            if (fire) begin
                if (exp_q.size() == 0) chk("rd_underflow", 1, 0);
                else                   chk("wave_out", int'(wave_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // The input count advances every clock; a sample written at a clock edge
    // equals the pin value driven two cycles earlier.
    task automatic step();
        @(negedge clk);
        digital_in = digital_in + 8'd1;
    endtask

    task automatic step_to(input logic [7:0] v);
        do step(); while (digital_in != v);
    endtask

    task automatic arm_cap(input logic [3:0] pre, input logic [15:0] div, input logic [7:0] base);
        step_to(base);
        pre_trig_len = pre;
        sample_div   = div;
        arm          = 1'b1;
        ts_cnt       = 0;
        step();
        arm          = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk("done_timeout", int'(done), 1);
    endtask

    task automatic read_all(input logic [7:0] first, input logic [7:0] stride);
        logic [7:0] v;
        v = first;
        for (int i = 0; i < 16; i++) begin
            step();
            wave_addr = 4'(i);
            rd_en     = 1'b1;
            exp_q.push_back(v);
            v = v + stride;
        end
        step();
        rd_en = 1'b0;
        step();
        chk("rd_drain", exp_q.size(), 0);
    endtask

    // sample_div=0 capture with a one-cycle trigger on sample ts.
    task automatic capture_div0(input logic [7:0] base, input logic [3:0] pre, input logic [7:0] ts);
        arm_cap(pre, 16'd0, base);
        step_to(ts + 8'd2);
        trig = 1'b1;
        for (int i = 0; i < 15 - int'(pre); i++) begin
            step();
            trig = 1'b0;
        end
        chk("done_early", int'(done), 0);
        step();
        trig = 1'b0;
        chk("done_on_time", int'(done), 1);
        chk("busy_after_done", int'(busy), 0);
        chk("trig_seen_once", ts_cnt, 1);
        read_all(ts - 8'(pre), 8'd1);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_waiting", int'(waiting), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_trig_seen", int'(trig_seen), 0);
        chk("rst_wave_out", int'(wave_out), 0);
        rstn = 1'b1;
        step();

        // 1: basic capture, trigger sample 0x20 with four pre-trigger samples
        capture_div0(8'h1A, 4'd4, 8'h20);

        // 2: empty pre-trigger window, trigger held from arm
        step_to(8'h40);
        pre_trig_len = 4'd0;
        sample_div   = 16'd0;
        arm          = 1'b1;
        trig         = 1'b1;
        ts_cnt       = 0;
        step();
        arm = 1'b0;
        chk("t2_waiting", int'(waiting), 1);
        repeat (16) step();
        chk("t2_done_early", int'(done), 0);
        step();
        trig = 1'b0;
        chk("t2_done", int'(done), 1);
        chk("t2_trig_seen_once", ts_cnt, 1);
        read_all(8'h40, 8'd1);

        // 3: full pre-trigger window, done right after the trigger tick
        capture_div0(8'h60, 4'd15, 8'h70);

        // 4: divide by 4, trigger pulse between ticks is remembered
        arm_cap(4'd2, 16'd3, 8'h80);
        step_to(8'h8A);
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("t4_no_trig_yet", ts_cnt, 0);
        chk("t4_waiting", int'(waiting), 1);
        repeat (2) step();
        chk("t4_trig_seen", ts_cnt, 1);
        wait_done(80);
        read_all(8'h82, 8'd4);

        // 5: triggers only during pre-trigger fill are ignored
        arm_cap(4'd4, 16'd0, 8'hC0);
        trig = 1'b1;
        repeat (2) step();
        trig = 1'b0;
        repeat (30) step();
        chk("t5_no_trig_seen", ts_cnt, 0);
        chk("t5_busy", int'(busy), 1);
        chk("t5_waiting", int'(waiting), 1);
        chk("t5_done", int'(done), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_busy", int'(busy), 0);

        // 6a: abort in the middle of the post-trigger fill
        arm_cap(4'd4, 16'd0, 8'h20);
        step_to(8'h2A);
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (3) step();
        chk("t6a_in_post", int'(busy & ~waiting), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6a_busy", int'(busy), 0);
        chk("t6a_done", int'(done), 0);
        chk("t6a_trig_seen", int'(trig_seen), 0);
        capture_div0(8'hA0, 4'd3, 8'hA8);

        // 6b: reset in the middle of the post-trigger fill
        arm_cap(4'd4, 16'd0, 8'h20);
        step_to(8'h2A);
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (3) step();
        rstn = 1'b0;
        step();
        chk("t6b_busy", int'(busy), 0);
        chk("t6b_done", int'(done), 0);
        chk("t6b_trig_seen", int'(trig_seen), 0);
        chk("t6b_wave_out", int'(wave_out), 0);
        rstn = 1'b1;
        step();
        capture_div0(8'hD0, 4'd5, 8'hDA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
